// File: rtl/cpu_pkg.sv
// Shared core definitions: datapath width, instruction size, reset vector
// and the fetch-queue entry bundle.
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous DEPTH x WIDTH FIFO with clear, count, full and empty flags.
// Ports: clk, reset_n (async, active-low), i_clear (wins over push/pop),
//   i_push/i_wdata, i_pop, o_rdata (head, zero when empty), o_count,
//   o_full, o_empty.  DEPTH must be a power of two >= 2.
module if_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_clear,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CW-1:0]    o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    logic w_do_pop;
    logic w_do_push;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

    // A push into a full FIFO is accepted when the head leaves this cycle.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
    end

    assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, issues credit-limited in-order
// requests to instruction memory, queues returned words with their PCs for
// decode, and discards stale responses after a redirect.
// Ports: clk, reset_n (async, active-low);
//   imem_req_valid/ready/addr  - fetch request port;
//   imem_rsp_valid/data        - in-order responses, one per request;
//   redirect_valid/pc          - taken branch/jump target;
//   stall                      - freeze PC and request issue;
//   out_valid/ready/instr/pc   - queue head towards decode;
//   if_flush                   - one-cycle flush pulse (also high in reset).
// Optional IF_FETCH_PERF_EN adds saturating counters perf_stall_cycles,
//   perf_dropped and perf_redirects.
module if_fetch_queue
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN,
    parameter int DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(cpu_pkg::RESET_PC)
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            if_flush
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_redirects
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0] r_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;
    logic            r_flush;

    logic            w_rsp;
    logic            w_drop;
    logic            w_push;
    logic            w_pop;
    logic            w_credit;
    logic            w_req_fire;
    entry_t          w_q_wdata;
    entry_t          w_q_rdata;
    logic [CW-1:0]   w_q_count;
    logic            w_q_full;
    logic            w_q_empty;
    logic [XLEN-1:0] w_t_pc;
    logic [CW-1:0]   w_t_count;
    logic            w_t_full;
    logic            w_t_empty;

    // A response without anything outstanding is ignored.
    assign w_rsp  = imem_rsp_valid && (r_outstanding != '0);
    assign w_drop = w_rsp && (r_drop_cnt != '0);
    assign w_push = w_rsp && !w_drop && !redirect_valid;
    assign w_pop  = out_valid && out_ready && !redirect_valid;

    // Queued plus in-flight words never exceed the queue size.
    assign w_credit = (int'(w_q_count) + int'(r_outstanding)) < DEPTH;

    assign imem_req_valid = reset_n && !stall && !redirect_valid && w_credit;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // Tracks addresses of live (non-stale) requests, oldest first.
    if_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_pc_track (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (redirect_valid),
        .i_push  (w_req_fire),
        .i_wdata (r_pc),
        .i_pop   (w_rsp && !w_drop),
        .o_rdata (w_t_pc),
        .o_count (w_t_count),
        .o_full  (w_t_full),
        .o_empty (w_t_empty)
    );

    assign w_q_wdata.instr = imem_rsp_data;
    assign w_q_wdata.pc    = w_t_pc;

    if_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_queue (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (redirect_valid),
        .i_push  (w_push),
        .i_wdata (w_q_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_q_rdata),
        .o_count (w_q_count),
        .o_full  (w_q_full),
        .o_empty (w_q_empty)
    );

    assign out_valid = !w_q_empty;
    assign out_instr = w_q_rdata.instr;
    assign out_pc    = w_q_rdata.pc;
    assign if_flush  = r_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc          <= {RESET_PC[XLEN-1:2], 2'b00};
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_flush       <= 1'b1;
        end else begin
            r_flush       <= redirect_valid;
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp);
            if (redirect_valid) begin
                r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
                // Every request still in flight after this edge is stale.
                r_drop_cnt <= r_outstanding - CW'(w_rsp);
            end else begin
                if (w_req_fire) r_pc <= r_pc + XLEN'(INSTR_BYTES);
                if (w_drop)     r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_drop;
    logic [31:0] r_perf_redir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_perf_stall <= '0;
            r_perf_drop  <= '0;
            r_perf_redir <= '0;
        end else begin
            if (!out_valid && out_ready && r_perf_stall != '1)
                r_perf_stall <= r_perf_stall + 32'd1;
            if (w_rsp && (w_drop || redirect_valid) && r_perf_drop != '1)
                r_perf_drop <= r_perf_drop + 32'd1;
            if (redirect_valid && r_perf_redir != '1)
                r_perf_redir <= r_perf_redir + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_dropped      = r_perf_drop;
    assign perf_redirects    = r_perf_redir;
`endif

    a_rsp_has_req: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> r_outstanding != '0);
    a_track_room: assert property (@(posedge clk) disable iff (!reset_n)
        w_req_fire |-> !w_t_full);
    a_track_live: assert property (@(posedge clk) disable iff (!reset_n)
        w_push |-> !w_t_empty);
    a_track_cnt: assert property (@(posedge clk) disable iff (!reset_n)
        w_t_count <= r_outstanding);
    a_queue_room: assert property (@(posedge clk) disable iff (!reset_n)
        (w_push && !w_pop) |-> !w_q_full);

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomised bench for if_fetch_queue against a queue-based reference
// model of fetch, in-order memory and stale-response dropping.
module tb_if_fetch_queue;
    import cpu_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        stall = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        if_flush;

    logic        wr_req_valid;
    logic [31:0] wr_req_addr;
    logic        wr_out_valid;
    logic [31:0] wr_out_instr;
    logic [31:0] wr_out_pc;
    logic        wr_flush;

`ifdef IF_FETCH_PERF_EN
    logic [31:0] perf_stall_cycles, perf_dropped, perf_redirects;
    logic [31:0] wr_ps, wr_pd, wr_pr;
`endif

    always #5 clk = ~clk;

    if_fetch_queue #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .if_flush(if_flush)
`ifdef IF_FETCH_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles),
        .perf_dropped(perf_dropped), .perf_redirects(perf_redirects)
`endif
    );

    if_fetch_queue #(
        .XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)
    ) dut_wrap (
        .clk(clk), .reset_n(reset_n),
        .imem_req_valid(wr_req_valid), .imem_req_ready(1'b1),
        .imem_req_addr(wr_req_addr),
        .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .stall(1'b0),
        .out_valid(wr_out_valid), .out_ready(1'b1),
        .out_instr(wr_out_instr), .out_pc(wr_out_pc),
        .if_flush(wr_flush)
`ifdef IF_FETCH_PERF_EN
        , .perf_stall_cycles(wr_ps),
        .perf_dropped(wr_pd), .perf_redirects(wr_pr)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          cyc;
    } req_t;

    int checks = 0;
    int errors = 0;

    req_t         pend[$];
    fetch_entry_t q_m[$];
    logic [31:0]  pc_m;
    bit           flush_m;
    int           cyc = 0;
    int           redir_m, drop_m, stall_m;
    bit           wrap_done = 0;

    int p_rdy = 100, p_rsp = 100, p_out = 100, p_stall = 0, lat = 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk_perf();
`ifdef IF_FETCH_PERF_EN
        chk("perf_redirects", perf_redirects, redir_m);
        chk("perf_dropped", perf_dropped, drop_m);
        chk("perf_stall_cycles", perf_stall_cycles, stall_m);
`endif
    endtask

    // Enters and leaves at a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        stall = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_flush", if_flush, 1);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_req_addr", imem_req_addr, 0);
        repeat (2) @(negedge clk);
        pend.delete();
        q_m.delete();
        pc_m = 32'h0;
        flush_m = 1;
        redir_m = 0;
        drop_m = 0;
        stall_m = 0;
        chk_perf();
        reset_n = 1'b1;
    endtask

    // One cycle: drive at falling edge, check, model the rising edge.
    task automatic step(input bit rd, input logic [31:0] rpc);
        bit   exp_rv, pop, fire, rv, empty;
        req_t r;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        stall          = ($urandom_range(99) < p_stall);
        out_ready      = ($urandom_range(99) < p_out);
        redirect_valid = rd;
        redirect_pc    = rpc;
        rv = 0;
        if (pend.size() > 0)
            rv = ((cyc - pend[0].cyc) >= lat) && ($urandom_range(99) < p_rsp);
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? mem_word(pend[0].addr) : $urandom();
        #1;
        empty  = (q_m.size() == 0);
        exp_rv = !stall && !rd && ((q_m.size() + pend.size()) < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        chk("req_addr", imem_req_addr, pc_m);
        chk("out_valid", out_valid, !empty);
        if (!empty) begin
            chk("out_pc", out_pc, q_m[0].pc);
            chk("out_instr", out_instr, q_m[0].instr);
        end
        chk("if_flush", if_flush, flush_m);
        pop  = !empty && out_ready;
        fire = exp_rv && imem_req_ready;
        if (empty && out_ready) stall_m++;
        @(posedge clk);
        cyc++;
        if (rd) begin
            if (rv) begin
                void'(pend.pop_front());
                drop_m++;
            end
            foreach (pend[i]) pend[i].stale = 1;
            q_m.delete();
            pc_m = rpc & ~32'h3;
            flush_m = 1;
            redir_m++;
        end else begin
            flush_m = 0;
            if (pop) void'(q_m.pop_front());
            if (rv) begin
                r = pend.pop_front();
                if (r.stale) drop_m++;
                else q_m.push_back('{instr: mem_word(r.addr), pc: r.addr});
            end
            if (fire) begin
                pend.push_back('{addr: pc_m, stale: 0, cyc: cyc});
                pc_m = pc_m + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input int p_redir);
        for (int i = 0; i < n; i++)
            step($urandom_range(99) < p_redir, $urandom() & 32'h0000_0FFF);
    endtask

    task automatic fill_inflight(input int k);
        for (int i = 0; i < 20 && pend.size() != k; i++) step(0, 32'h0);
        chk("inflight_setup", pend.size(), k);
    endtask

    initial begin
        logic [31:0] got[$];
        @(posedge reset_n);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (wr_req_valid) got.push_back(wr_req_addr);
            @(negedge clk);
            #1;
        end
        chk("wrap_count", got.size(), 4);
        if (got.size() >= 3) begin
            chk("wrap_addr0", got[0], 32'hFFFF_FFF8);
            chk("wrap_addr1", got[1], 32'hFFFF_FFFC);
            chk("wrap_addr2", got[2], 32'h0000_0000);
        end
        chk("wrap_out_valid", wr_out_valid, 0);
        wrap_done = 1;
    end

    initial begin
        do_reset();

        // streaming at latency 1
        p_rdy = 100; p_rsp = 100; p_out = 100; p_stall = 0; lat = 1;
        run(20, 0);

        // backpressure then release
        p_out = 0;
        run(15, 0);
        p_out = 100;
        run(15, 0);

        // redirect with two responses in flight at latency 3
        lat = 3;
        step(1, 32'h0000_0040);
        fill_inflight(2);
        step(1, 32'h0000_0100);
        run(12, 0);
        fill_inflight(2);
        step(1, 32'h0000_0103);
        run(12, 0);
        chk_perf();

        // stall with two responses pending
        step(1, 32'h0000_0200);
        fill_inflight(2);
        p_stall = 100;
        run(5, 0);
        p_stall = 0;
        run(10, 0);

        // back-to-back redirects
        step(1, 32'h0000_0300);
        step(1, 32'h0000_0400);
        run(10, 0);
        chk_perf();

        // randomised traffic with a mid-run reset
        for (int ph = 0; ph < 60; ph++) begin
            p_rdy   = $urandom_range(30, 100);
            p_rsp   = $urandom_range(30, 100);
            p_out   = $urandom_range(20, 100);
            p_stall = $urandom_range(0, 30);
            lat     = $urandom_range(1, 4);
            run(50, $urandom_range(0, 8));
            if (ph == 30) begin
                do_reset();
            end
        end
        chk_perf();

        if (!wrap_done) chk("wrap_done", wrap_done, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Parametrised instruction-fetch stage for the pipelined core.
- Owns the PC and issues in-order requests to instruction memory over a valid/ready port with variable latency.
- Buffers returned instructions with their PCs in a DEPTH-entry queue that feeds decode over a valid/ready handshake.
- Accepts a single merged redirect (branch/jump); after a redirect, stale in-flight responses are discarded and a flush pulse goes to the pipeline.

Parameters:
- XLEN, 32, width of PC and instruction.
- DEPTH, 4, queue entries; power of two, ≥2; also the limit on outstanding memory requests.
- RESET_PC, 32'h0000_0000, PC value after reset.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address, low 2 bits always 0.
- imem_rsp_valid  in  1  response valid; responses arrive in order, one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  in  XLEN  instruction word.
- redirect_valid  in  1  branch/jump taken.
- redirect_pc  in  XLEN  target address.
- stall  in  1  hold PC and issue no new requests (replaces IFWrite=0).
- out_valid  out  1  queue head valid to decode.
- out_ready  in  1  decode consumes head.
- out_instr  out  XLEN  head instruction.
- out_pc  out  XLEN  head PC.
- if_flush  out  1  pipeline flush pulse.

Behaviour:
- Reset (async assert, sync deassert by the system) sets:
  - pc=RESET_PC;
  - queue empty, so out_valid=0 and out_instr/out_pc=0;
  - outstanding=0, drop_cnt=0;
  - imem_req_valid=0;
  - if_flush=1.
  - if_flush clears on the first clock edge after reset_n rises.
- Request issue:
  - imem_req_valid=1 iff reset is inactive, stall=0, redirect_valid=0, and (queue_count + outstanding) < DEPTH.
  - Credit rule: the queue can never overflow.
  - imem_req_addr=pc.
  - On handshake: pc <= pc+4 (mod 2^XLEN, wraps silently) and outstanding++.
- Response:
  - Each imem_rsp_valid cycle does outstanding--.
  - If drop_cnt>0: drop_cnt-- and the data is discarded.
  - Otherwise push {instr, pc_of_request} into the queue. A shadow PC FIFO of DEPTH entries, or equivalent, tracks in-flight addresses.
- Output:
  - out_* reflect the queue head combinationally from registers.
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop in one cycle is allowed, including at count=DEPTH-1 and at count=1.
  - Push to an empty queue becomes visible on out_valid the next cycle (1-cycle response→decode latency).
- Redirect has the highest priority:
  - On redirect_valid: pc <= {redirect_pc[XLEN-1:2],2'b00}; queue cleared, with any same-cycle pop or push ignored.
  - drop_cnt <= outstanding minus a same-cycle response, plus a same-cycle request (none issued because req_valid is gated).
  - if_flush=1 for exactly the next cycle.
  - Requests resume the cycle after redirect.
  - Redirects in back-to-back cycles: the last one wins; drop_cnt is recomputed each time.
- Stall:
  - Freezes pc and request issue only.
  - Responses still fill the queue and decode may still pop.
  - A redirect during stall is still taken.
- Boundaries:
  - Queue full with out_ready=0: no request issues, and no response can arrive because of credits.
  - outstanding and drop_cnt are each $clog2(DEPTH)+1 bits wide.
  - A response with outstanding=0 is a protocol error (assertion only; state is unchanged).

Optional Feature:
- Macro IF_FETCH_PERF_EN.
- When defined:
  - adds outputs perf_stall_cycles[31:0] (cycles with out_valid=0 and out_ready=1);
  - adds perf_dropped[31:0] (discarded responses);
  - adds perf_redirects[31:0].
  - All three reset to 0, saturate at all-ones, and add no combinational paths to the existing outputs.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cpu_pkg holds:
  - XLEN default;
  - INSTR_BYTES=4;
  - RESET_PC default;
  - typedef fetch_entry_t {instr, pc}.
- One sub-module, if_sync_fifo: parametrised DEPTH × width synchronous FIFO with push, pop, clear, count, full, and empty. It is instantiated for the output queue and for the in-flight PC tracker.

Test Plan:
- Reset: hold reset_n=0 mid-run, then release → pc=0, out_valid=0, if_flush=1 for one cycle; first request addr=0x0.
- Streaming: memory latency 1 with out_ready=1 → decode sees PCs 0x0, 0x4, 0x8, 0xC on consecutive cycles with matching data.
- Backpressure: out_ready=0 and DEPTH=4 → exactly 4 requests accepted, then req_valid=0; out_ready=1 → requests resume; no entry is lost or duplicated.
- Redirect: redirect to 0x100 with 2 responses in flight at latency 3 → both responses dropped, if_flush pulses once, next out_pc=0x100. Repeat with redirect_pc=0x103 → fetch from 0x100.
- Stall: stall=1 for 5 cycles with 2 responses pending → the 2 entries still arrive in the queue, no new requests, pc unchanged.
- Wrap: RESET_PC=0xFFFF_FFF8 → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. With IF_FETCH_PERF_EN, perf_redirects increments by exactly 1 per redirect.
